// File: rtl/adc_acq_ctrl_if.sv
// Signal bundle between the ADC acquisition controller and its host/datapath.
// The controller side uses the slave modport; the driving side uses master.
interface adc_acq_ctrl_if;
   logic        dma_start;
   logic        abort;
   logic        trig_ex;
   logic [13:0] wave_len_i;
   logic [13:0] cycle_i;
   logic [19:0] delay_i;
   logic        prog_full;
   logic        capture_en;
   logic        seg_last;
   logic [13:0] seg_idx;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic        overrun;
   logic [7:0]  missed_trig;
   logic        timeout;

   modport master (
      output dma_start, abort, trig_ex, wave_len_i, cycle_i, delay_i, prog_full,
      input  capture_en, seg_last, seg_idx, busy, done, cfg_err, overrun,
             missed_trig, timeout
   );

   modport slave (
      input  dma_start, abort, trig_ex, wave_len_i, cycle_i, delay_i, prog_full,
      output capture_en, seg_last, seg_idx, busy, done, cfg_err, overrun,
             missed_trig, timeout
   );
endinterface

// File: rtl/adc_acq_ctrl.sv
// Triggered multi-segment ADC capture sequencer with delay, drop and missed-trigger tracking.
// Optional trigger-wait timeout is built when ADC_ACQ_TRIG_TIMEOUT_EN is defined.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | waiting for dma_start; a start is acted on one cycle later
//   ST_ARM     | waiting for a trigger rising edge (optionally timed out)
//   ST_DELAY   | counting trigger-to-capture delay
//   ST_CAPTURE | counting wave_len beats of one segment
//   ST_DONE    | one-cycle done pulse, then back to idle
module adc_acq_ctrl #(
   parameter logic [31:0] TIMEOUT_CYC = 32'd125000000
) (
   input  logic          clk_125M,
   input  logic          reset_n,
   adc_acq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_DELAY,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        start_pend_q, start_pend_d;
   logic [13:0] wave_len_q, wave_len_d;
   logic [13:0] cycle_q, cycle_d;
   logic [19:0] delay_q, delay_d;
   logic [19:0] dly_cnt_q, dly_cnt_d;
   logic [13:0] beat_cnt_q, beat_cnt_d;
   logic [13:0] seg_idx_q, seg_idx_d;
   logic        cfg_err_q, cfg_err_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  missed_q, missed_d;
   logic        trig_prev_q;

   logic        trig_edge;
   logic        start_acc;
   logic        tmo_hit;
   logic        tmo_fire;
   logic        timeout_flag;

   assign trig_edge = bus.trig_ex & ~trig_prev_q;
   assign start_acc = (state_q == ST_IDLE) && !start_pend_q && bus.dma_start && !bus.abort;
   assign tmo_fire  = (state_q == ST_ARM) && !bus.abort && !trig_edge && tmo_hit;

`ifdef ADC_ACQ_TRIG_TIMEOUT_EN
   logic [31:0] tmo_cnt_q;
   logic        timeout_q;

   assign tmo_hit      = (tmo_cnt_q == 32'd0);
   assign timeout_flag = timeout_q;

   // Reloaded on every entry into ARM, so each segment gets a full wait budget.
   always_ff @(posedge clk_125M or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q <= 32'd0;
         timeout_q <= 1'b0;
      end else begin
         if (start_acc)
            timeout_q <= 1'b0;
         else if (tmo_fire)
            timeout_q <= 1'b1;
         if ((state_d == ST_ARM) && (state_q != ST_ARM))
            tmo_cnt_q <= TIMEOUT_CYC;
         else if ((state_q == ST_ARM) && (tmo_cnt_q != 32'd0))
            tmo_cnt_q <= tmo_cnt_q - 32'd1;
      end
   end
`else
   logic tmo_unused;

   assign tmo_unused   = ^TIMEOUT_CYC;
   assign tmo_hit      = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      start_pend_d = start_pend_q;
      wave_len_d   = wave_len_q;
      cycle_d      = cycle_q;
      delay_d      = delay_q;
      dly_cnt_d    = dly_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      seg_idx_d    = seg_idx_q;
      cfg_err_d    = cfg_err_q;
      overrun_d    = overrun_q;
      missed_d     = missed_q;

      if (bus.abort) begin
         state_d      = ST_IDLE;
         start_pend_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_pend_q) begin
                  start_pend_d = 1'b0;
                  if ((wave_len_q == 14'd0) || (cycle_q == 14'd0)) begin
                     cfg_err_d = 1'b1;
                     state_d   = ST_DONE;
                  end else begin
                     state_d = ST_ARM;
                  end
               end else if (start_acc) begin
                  start_pend_d = 1'b1;
                  wave_len_d   = bus.wave_len_i;
                  cycle_d      = bus.cycle_i;
                  delay_d      = bus.delay_i;
                  seg_idx_d    = 14'd0;
                  cfg_err_d    = 1'b0;
                  overrun_d    = 1'b0;
                  missed_d     = 8'd0;
               end
            end
            ST_ARM: begin
               if (trig_edge) begin
                  if (delay_q == 20'd0) begin
                     state_d    = ST_CAPTURE;
                     beat_cnt_d = wave_len_q - 14'd1;
                  end else begin
                     state_d   = ST_DELAY;
                     dly_cnt_d = delay_q - 20'd1;
                  end
               end else if (tmo_fire) begin
                  state_d = ST_DONE;
               end
            end
            ST_DELAY: begin
               if (trig_edge && (missed_q != 8'hFF))
                  missed_d = missed_q + 8'd1;
               if (dly_cnt_q == 20'd0) begin
                  state_d    = ST_CAPTURE;
                  beat_cnt_d = wave_len_q - 14'd1;
               end else begin
                  dly_cnt_d = dly_cnt_q - 20'd1;
               end
            end
            ST_CAPTURE: begin
               if (trig_edge && (missed_q != 8'hFF))
                  missed_d = missed_q + 8'd1;
               if (bus.prog_full)
                  overrun_d = 1'b1;
               // Dropped beats still consume the segment, so the length is time-exact.
               if (beat_cnt_q == 14'd0) begin
                  if ((seg_idx_q + 14'd1) < cycle_q) begin
                     seg_idx_d = seg_idx_q + 14'd1;
                     state_d   = ST_ARM;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q - 14'd1;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_125M or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         start_pend_q <= 1'b0;
         wave_len_q   <= 14'd0;
         cycle_q      <= 14'd0;
         delay_q      <= 20'd0;
         dly_cnt_q    <= 20'd0;
         beat_cnt_q   <= 14'd0;
         seg_idx_q    <= 14'd0;
         cfg_err_q    <= 1'b0;
         overrun_q    <= 1'b0;
         missed_q     <= 8'd0;
         trig_prev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_pend_q <= start_pend_d;
         wave_len_q   <= wave_len_d;
         cycle_q      <= cycle_d;
         delay_q      <= delay_d;
         dly_cnt_q    <= dly_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         seg_idx_q    <= seg_idx_d;
         cfg_err_q    <= cfg_err_d;
         overrun_q    <= overrun_d;
         missed_q     <= missed_d;
         trig_prev_q  <= bus.trig_ex;
      end
   end

   assign bus.capture_en  = (state_q == ST_CAPTURE) && !bus.prog_full && !bus.abort;
   assign bus.seg_last    = bus.capture_en && (beat_cnt_q == 14'd0);
   assign bus.seg_idx     = seg_idx_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.cfg_err     = cfg_err_q;
   assign bus.overrun     = overrun_q;
   assign bus.missed_trig = missed_q;
   assign bus.timeout     = timeout_flag;

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Bench for adc_acq_ctrl: directed scenarios plus randomized runs against an
// interval-level reference model of segment windows, drops and missed triggers.
module tb_adc_acq_ctrl;
   localparam int LEN = 1024;

   logic clk_125M = 1'b0;
   logic reset_n;
   always #4 clk_125M = ~clk_125M;

   adc_acq_ctrl_if bus ();

   adc_acq_ctrl #(.TIMEOUT_CYC(32'd100)) dut (
      .clk_125M (clk_125M),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   bit trig_a [LEN];
   bit pf_a   [LEN];
   bit inj_en;
   int cfg_wl, cfg_cy, cfg_dl;

   bit exp_cap  [LEN];
   bit exp_last [LEN];
   bit exp_done [LEN];
   bit exp_busy [LEN];
   int exp_seg  [LEN];
   int end_c, exp_missed;
   bit exp_ovr, exp_cfg;
   int obs_done_c, obs_beats, obs_first;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive just after the rising edge, return at the falling edge.
   task automatic cyc(input bit st, input bit tr, input bit pf, input bit ab, input bit use_cfg);
      @(posedge clk_125M);
      #1;
      bus.dma_start = st;
      bus.trig_ex   = tr;
      bus.prog_full = pf;
      bus.abort     = ab;
      if (use_cfg) begin
         bus.wave_len_i = 14'(cfg_wl);
         bus.cycle_i    = 14'(cfg_cy);
         bus.delay_i    = 20'(cfg_dl);
      end else begin
         bus.wave_len_i = 14'($urandom);
         bus.cycle_i    = 14'($urandom);
         bus.delay_i    = 20'($urandom);
      end
      @(negedge clk_125M);
   endtask

   task automatic clear_stim();
      for (int c = 0; c < LEN; c++) begin
         trig_a[c] = 1'b0;
         pf_a[c]   = 1'b0;
      end
   endtask

   // Start at cycle 0 is acted on at cycle 1; arming begins at cycle 2. Each segment
   // waits for the first rising edge t, then captures [t+1+dl, t+dl+wl].
   task automatic model(input int wl, input int cy, input int dl);
      int a, t, c0, ce;
      for (int c = 0; c < LEN; c++) begin
         exp_cap[c] = 0; exp_last[c] = 0; exp_done[c] = 0; exp_busy[c] = 0; exp_seg[c] = -1;
      end
      exp_missed = 0; exp_ovr = 0; exp_cfg = 0;
      if (wl == 0 || cy == 0) begin
         exp_cfg = 1;
         end_c   = 2;
      end else begin
         a = 2;
         for (int s = 0; s < cy; s++) begin
            t = a;
            while (t < LEN - 1 && !(trig_a[t] && !trig_a[t-1])) t++;
            c0 = t + 1 + dl;
            ce = c0 + wl - 1;
            for (int c = a; c <= ce && c < LEN; c++) exp_busy[c] = 1;
            for (int c = c0; c <= ce && c < LEN; c++) begin
               exp_seg[c] = s;
               if (pf_a[c]) exp_ovr = 1;
               else begin
                  exp_cap[c]  = 1;
                  exp_last[c] = (c == ce);
               end
            end
            for (int c = t + 1; c <= ce && c < LEN; c++)
               if (trig_a[c] && !trig_a[c-1] && exp_missed < 255) exp_missed++;
            a = ce + 1;
         end
         end_c = a;
      end
      if (end_c > LEN - 2) end_c = LEN - 2;
      exp_done[end_c] = 1;
      exp_busy[end_c] = 1;
   endtask

   task automatic run_scenario(input int wl, input int cy, input int dl);
      bit st;
      model(wl, cy, dl);
      cfg_wl = wl; cfg_cy = cy; cfg_dl = dl;
      obs_done_c = -1; obs_beats = 0; obs_first = -1;
      for (int c = 0; c <= end_c + 1; c++) begin
         st = (c == 0) || (inj_en && c >= 2 && c <= end_c && $urandom_range(0, 7) == 0);
         cyc(st, trig_a[c], pf_a[c], 1'b0, c == 0);
         chk("capture_en", bus.capture_en, exp_cap[c]);
         chk("seg_last", bus.seg_last, exp_last[c]);
         chk("done", bus.done, exp_done[c]);
         chk("busy", bus.busy, exp_busy[c]);
         if (exp_seg[c] >= 0) chk("seg_idx", bus.seg_idx, exp_seg[c]);
         if (bus.capture_en === 1'b1) begin
            obs_beats++;
            if (obs_first < 0) obs_first = c;
         end
         if (bus.done === 1'b1 && obs_done_c < 0) obs_done_c = c;
      end
      chk("overrun", bus.overrun, exp_ovr);
      chk("missed_trig", bus.missed_trig, exp_missed);
      chk("cfg_err", bus.cfg_err, exp_cfg);
      chk("timeout_clr", bus.timeout, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   int cnt_done, cnt_cap, cnt_busy, first_done;

   initial begin
      reset_n = 1'b0;
      bus.dma_start = 0; bus.abort = 0; bus.trig_ex = 0; bus.prog_full = 0;
      bus.wave_len_i = 0; bus.cycle_i = 0; bus.delay_i = 0;
      inj_en = 0;
      #20;
      chk("rst_capture_en", bus.capture_en, 0);
      chk("rst_seg_last", bus.seg_last, 0);
      chk("rst_seg_idx", bus.seg_idx, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_cfg_err", bus.cfg_err, 0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_missed", bus.missed_trig, 0);
      chk("rst_timeout", bus.timeout, 0);
      @(negedge clk_125M);
      reset_n = 1'b1;
      cyc(0, 0, 0, 0, 0);

      // Two segments, level held from before ARM must not trigger.
      clear_stim();
      for (int c = 0; c < 4; c++) trig_a[c] = 1;
      trig_a[5] = 1; trig_a[25] = 1;
      run_scenario(4, 2, 0);
      chk("r039_first_beat", obs_first, 6);
      chk("r039_beats", obs_beats, 8);
      chk("r039_done_cycle", obs_done_c, 30);

      clear_stim();
      trig_a[8] = 1;
      run_scenario(3, 1, 10);
      chk("r040_first_beat", obs_first, 19);
      chk("r040_beats", obs_beats, 3);

      clear_stim();
      trig_a[6] = 1; pf_a[9] = 1; pf_a[10] = 1;
      run_scenario(8, 1, 0);
      chk("r041_beats", obs_beats, 6);
      chk("r041_overrun", bus.overrun, 1);
      chk("r041_done_cycle", obs_done_c, 15);

      clear_stim();
      trig_a[6] = 1; trig_a[8] = 1; trig_a[10] = 1; trig_a[12] = 1;
      run_scenario(8, 1, 0);
      chk("r042_missed", bus.missed_trig, 3);
      chk("r042_beats", obs_beats, 8);
      chk("r042_done_cycle", obs_done_c, 15);

      clear_stim();
      run_scenario(0, 1, 0);
      chk("r043_cfg_err", bus.cfg_err, 1);
      chk("r043_done_cycle", obs_done_c, 2);
      chk("r043_beats", obs_beats, 0);

      // Missed-trigger counter saturates during a long delay.
      clear_stim();
      trig_a[5] = 1;
      for (int c = 8; c < 640; c += 2) trig_a[c] = 1;
      run_scenario(1, 1, 700);
      chk("sat_missed", bus.missed_trig, 255);

      // Abort during DELAY, together with a start request.
      cfg_wl = 4; cfg_cy = 1; cfg_dl = 20;
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("abort_pre_busy", bus.busy, 1);
      cyc(1, 0, 0, 1, 1);
      chk("abort_cyc_cap", bus.capture_en, 0);
      cyc(0, 0, 0, 0, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_missed_hold", bus.missed_trig, 1);
      cnt_done = 0; cnt_cap = 0; cnt_busy = 0;
      for (int c = 0; c < 30; c++) begin
         cyc(0, 1'($urandom), 0, 0, 0);
         if (bus.done !== 1'b0) cnt_done++;
         if (bus.capture_en !== 1'b0) cnt_cap++;
         if (bus.busy !== 1'b0) cnt_busy++;
      end
      chk("abort_no_done", cnt_done, 0);
      chk("abort_no_capture", cnt_cap, 0);
      chk("abort_stays_idle", cnt_busy, 0);
      cyc(0, 0, 0, 0, 0);

      // Trigger wait with no trigger.
      cfg_wl = 2; cfg_cy = 1; cfg_dl = 0;
      cyc(1, 0, 0, 0, 1);
      first_done = -1; cnt_cap = 0;
`ifdef ADC_ACQ_TRIG_TIMEOUT_EN
      for (int c = 1; c <= 130; c++) begin
         cyc(0, 0, 0, 0, 0);
         if (bus.done === 1'b1 && first_done < 0) first_done = c;
         if (bus.capture_en !== 1'b0) cnt_cap++;
      end
      chk("tmo_done_cycle", first_done, 103);
      chk("tmo_flag", bus.timeout, 1);
      chk("tmo_no_capture", cnt_cap, 0);
`else
      for (int c = 1; c <= 150; c++) begin
         cyc(0, 0, 0, 0, 0);
         if (bus.done === 1'b1 && first_done < 0) first_done = c;
         if (bus.capture_en !== 1'b0) cnt_cap++;
      end
      chk("notmo_no_done", first_done, -1);
      chk("notmo_still_busy", bus.busy, 1);
      chk("notmo_flag", bus.timeout, 0);
      chk("notmo_no_capture", cnt_cap, 0);
      cyc(0, 0, 0, 1, 0);
`endif
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Randomized acquisitions with config churn and ignored restarts.
      inj_en = 1;
      for (int it = 0; it < 25; it++) begin
         for (int c = 0; c < LEN; c++) begin
            trig_a[c] = ($urandom_range(0, 3) == 0);
            pf_a[c]   = ($urandom_range(0, 4) == 0);
         end
         run_scenario($urandom_range(0, 10), $urandom_range(0, 3),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6));
      end
      inj_en = 0;

      // Reset in the middle of a segment drops capture_en immediately.
      cfg_wl = 8; cfg_cy = 1; cfg_dl = 0;
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("midrst_cap_before", bus.capture_en, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_cap_after", bus.capture_en, 0);
      chk("midrst_busy", bus.busy, 0);
      @(negedge clk_125M);
      reset_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      chk("midrst_idle_busy", bus.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/adc_acq_ctrl.md
ADC_ACQ_CTRL -- requirements
Module: adc_acq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 32'd125000000, meaning the trigger-wait timeout in clk_125M cycles (1 s).
REQ-002 SHALL have port clk_125M, input, 1, the sole clock.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port dma_start, input, 1, single-cycle acquisition start pulse.
REQ-005 SHALL have port abort, input, 1, level; forces return to IDLE.
REQ-006 SHALL have port trig_ex, input, 1, external trigger, already synchronous to clk_125M.
REQ-007 SHALL have port wave_len_i, input, 14, segment length in 512-bit beats.
REQ-008 SHALL have port cycle_i, input, 14, number of segments per acquisition.
REQ-009 SHALL have port delay_i, input, 20, trigger-to-capture delay in cycles.
REQ-010 SHALL have port prog_full, input, 1, downstream FIFO almost-full.
REQ-011 SHALL have port capture_en, output, 1, qualifies the ADC beat as written this cycle.
REQ-012 SHALL have port seg_last, output, 1, high on the final beat of each segment.
REQ-013 SHALL have port seg_idx, output, 14, index of the current segment, 0-based.
REQ-014 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-015 SHALL have port done, output, 1, single-cycle end-of-acquisition pulse.
REQ-016 SHALL have port cfg_err, output, 1, sticky zero-length or zero-cycle configuration error.
REQ-017 SHALL have port overrun, output, 1, sticky flag: a beat was dropped due to prog_full.
REQ-018 SHALL have port missed_trig, output, 8, saturating count of triggers ignored while in DELAY or CAPTURE.
REQ-019 SHALL have port timeout, output, 1, sticky trigger-wait timeout flag.

Function
REQ-020 SHALL implement states IDLE, ARM, DELAY, CAPTURE and DONE.
REQ-021 SHALL latch wave_len_i, cycle_i and delay_i on dma_start in IDLE; later input changes SHALL NOT affect a running acquisition.
REQ-022 SHALL clear cfg_err, overrun, missed_trig, timeout and seg_idx on an accepted dma_start.
REQ-023 SHALL, when latched wave_len or cycle is 0 at start, set cfg_err and go IDLE->DONE with no capture_en.
REQ-024 SHALL otherwise move IDLE->ARM; dma_start in any non-IDLE state SHALL be ignored.
REQ-025 SHALL detect the trigger as a rising edge (trig_ex=1 at cycle T, 0 at T-1); a level held high from before ARM SHALL NOT trigger.
REQ-026 SHALL, on an edge at T in ARM: with delay=0, go CAPTURE with the first capture beat at T+1; with delay=N, go DELAY with the first capture beat at T+1+N.
REQ-027 SHALL count exactly wave_len beats in CAPTURE; a beat SHALL count even when dropped.
REQ-028 SHALL drive capture_en = in CAPTURE AND NOT prog_full; a beat with prog_full=1 SHALL set overrun.
REQ-029 SHALL assert seg_last on the last counted beat, gated like capture_en.
REQ-030 SHALL, after the last beat, increment seg_idx and return to ARM if seg_idx+1 < cycle, else go to DONE.
REQ-031 SHALL increment missed_trig, saturating at 255, on each trigger edge seen in DELAY or CAPTURE.
REQ-032 SHALL hold DONE for one cycle with done=1, then go to IDLE.
REQ-033 SHALL, on abort=1 in any state, go to IDLE next cycle with capture_en=0; done SHALL NOT pulse and sticky flags SHALL hold.
REQ-034 SHALL give abort priority over a simultaneous dma_start or trigger.

Reset
REQ-035 SHALL, on reset_n=0, asynchronously enter IDLE with every output 0 and all counters and latched configuration cleared.
REQ-036 SHALL, on reset mid-CAPTURE, drop capture_en within the same cycle.

Configuration
REQ-037 SHALL, when ADC_ACQ_TRIG_TIMEOUT_EN is defined, count cycles in ARM and on reaching TIMEOUT_CYC without a trigger set timeout and go to DONE.
REQ-038 SHALL, when ADC_ACQ_TRIG_TIMEOUT_EN is undefined, wait in ARM indefinitely, tie timeout to 0 and omit the counter.

Verification
REQ-039 SHALL cover: wave_len=4, cycle=2, delay=0, trigger edges at T0 and T0+20 -> capture_en at T0+1..T0+4 and T0+21..T0+24, seg_last at T0+4 and T0+24, done at T0+25.
REQ-040 SHALL cover: delay=10, wave_len=3, edge at T -> capture_en at T+11..T+13.
REQ-041 SHALL cover: prog_full high for 2 cycles mid-segment of wave_len=8 -> 6 capture_en beats, overrun=1, segment still ends 8 cycles after it starts.
REQ-042 SHALL cover: 3 trigger edges during an 8-beat CAPTURE -> missed_trig=3 with no extra segment.
REQ-043 SHALL cover: wave_len=0 -> cfg_err=1 and done 2 cycles after dma_start, with no capture_en.
REQ-044 SHALL cover: abort during DELAY, and TIMEOUT_CYC=100 with the macro defined and no trigger -> IDLE with no done in the abort case; timeout=1 and done 101 cycles after entering ARM in the timeout case.
